fb_write_collector: RTL and testbench

//  Consumer end of the per-PPU pixel write streams (ppu_data/ppu_address/ppu_valid, one lane per core).

---
 rtl/fb_write_collector.sv | 181 ++++++++++++++++++
 tb/tb_fb_write_collector.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fb_write_collector.sv
// fb_write_collector: per-PPU lane FIFOs, round-robin arbitration onto one framebuffer write master,
// local-to-global address mapping and frame completion pulse. Define FB_WRITE_STATS_EN for dropped_count.
//
// state | meaning
// IDLE  | accepting beats, no frame completion pending
// DRAIN | frame_end seen, waiting until every queued beat has committed
module fb_write_collector #(
   parameter int COLOR_WIDTH   = 16,
   parameter int CORES_COUNT   = 10,
   parameter int BUFFER_ADDR_W = 32,
   parameter int SCREEN_X_SIZE = 800,
   parameter int SCREEN_Y_SIZE = 600,
   parameter int FIFO_DEPTH    = 4,
   parameter logic [BUFFER_ADDR_W-1:0] FB_BASE = '0
) (
   input  logic                                  clk,
   input  logic                                  reset_n,
   input  logic [COLOR_WIDTH*CORES_COUNT-1:0]    ppu_data,
   input  logic [BUFFER_ADDR_W*CORES_COUNT-1:0]  ppu_address,
   input  logic [CORES_COUNT-1:0]                ppu_valid,
   input  logic                                  frame_end,
   output logic [BUFFER_ADDR_W-1:0]              mem_address,
   output logic [COLOR_WIDTH-1:0]                mem_writedata,
   output logic                                  mem_write,
   input  logic                                  mem_waitrequest,
   output logic                                  busy,
   output logic                                  frame_written,
   output logic                                  overflow
`ifdef FB_WRITE_STATS_EN
   ,
   output logic [15:0]                           dropped_count
`endif
);

   localparam int LW = (CORES_COUNT > 1) ? $clog2(CORES_COUNT) : 1;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int EW = COLOR_WIDTH + BUFFER_ADDR_W;
   localparam logic [BUFFER_ADDR_W-1:0] LANE_PIXELS =
      BUFFER_ADDR_W'((SCREEN_Y_SIZE / CORES_COUNT) * SCREEN_X_SIZE);
   localparam logic [BUFFER_ADDR_W-1:0] PIXEL_BYTES = BUFFER_ADDR_W'(COLOR_WIDTH / 8);
   localparam logic [LW-1:0] LAST_LANE = LW'(CORES_COUNT - 1);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_DRAIN = 1'b1;

   logic [EW-1:0]            fifo_mem [CORES_COUNT][FIFO_DEPTH];
   logic [PW:0]              wr_ptr [CORES_COUNT];
   logic [PW:0]              rd_ptr [CORES_COUNT];
   logic [CORES_COUNT-1:0]   empty, full, req, push, pop, bypass, drop;
   logic [LW-1:0]            rr_ptr, grant_idx;
   logic                     grant_valid, load_en, take;
   logic [EW-1:0]            head_entry, in_entry, sel_entry;
   logic [BUFFER_ADDR_W-1:0] lane_base, mapped_addr;
   logic [0:0]               state;
   int                       idx;

   always_comb begin
      for (int i = 0; i < CORES_COUNT; i++) begin
         empty[i] = (wr_ptr[i] == rd_ptr[i]);
         full[i]  = (wr_ptr[i][PW] != rd_ptr[i][PW]) &&
                    (wr_ptr[i][PW-1:0] == rd_ptr[i][PW-1:0]);
      end
   end

   // An incoming beat on an empty lane can be granted directly, giving one-cycle latency.
   assign req     = ~empty | ppu_valid;
   assign load_en = !mem_write || !mem_waitrequest;
   assign take    = grant_valid && load_en;

   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      idx         = 0;
      for (int k = 0; k < CORES_COUNT; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= CORES_COUNT) idx = idx - CORES_COUNT;
         if (!grant_valid && req[idx]) begin
            grant_valid = 1'b1;
            grant_idx   = LW'(idx);
         end
      end
   end

   always_comb begin
      pop    = '0;
      bypass = '0;
      push   = '0;
      drop   = '0;
      for (int i = 0; i < CORES_COUNT; i++) begin
         pop[i]    = take && (grant_idx == LW'(i)) && !empty[i];
         bypass[i] = take && (grant_idx == LW'(i)) && empty[i];
         push[i]   = ppu_valid[i] && !bypass[i] && (!full[i] || pop[i]);
         drop[i]   = ppu_valid[i] && !bypass[i] && full[i] && !pop[i];
      end
   end

   always_comb begin
      head_entry  = fifo_mem[grant_idx][rd_ptr[grant_idx][PW-1:0]];
      in_entry    = {ppu_data[grant_idx*COLOR_WIDTH +: COLOR_WIDTH],
                     ppu_address[grant_idx*BUFFER_ADDR_W +: BUFFER_ADDR_W]};
      sel_entry   = empty[grant_idx] ? in_entry : head_entry;
      lane_base   = BUFFER_ADDR_W'(grant_idx) * LANE_PIXELS;
      mapped_addr = FB_BASE + (lane_base + sel_entry[BUFFER_ADDR_W-1:0]) * PIXEL_BYTES;
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < CORES_COUNT; i++) begin
         if (push[i])
            fifo_mem[i][wr_ptr[i][PW-1:0]] <=
               {ppu_data[i*COLOR_WIDTH +: COLOR_WIDTH],
                ppu_address[i*BUFFER_ADDR_W +: BUFFER_ADDR_W]};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < CORES_COUNT; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
         end
      end else begin
         for (int i = 0; i < CORES_COUNT; i++) begin
            if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
            if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_write     <= 1'b0;
         mem_address   <= '0;
         mem_writedata <= '0;
         rr_ptr        <= '0;
      end else if (take) begin
         mem_write     <= 1'b1;
         mem_address   <= mapped_addr;
         mem_writedata <= sel_entry[EW-1 -: COLOR_WIDTH];
         rr_ptr        <= (grant_idx == LAST_LANE) ? '0 : grant_idx + 1'b1;
      end else if (!mem_waitrequest) begin
         mem_write     <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         overflow <= 1'b0;
      else if (|drop)
         overflow <= 1'b1;
   end

   assign busy          = (|(~empty)) | mem_write;
   assign frame_written = (state == ST_DRAIN) && !busy;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= ST_IDLE;
      else if (state == ST_IDLE && frame_end)
         state <= ST_DRAIN;
      else if (state == ST_DRAIN && !busy)
         state <= ST_IDLE;
   end

`ifdef FB_WRITE_STATS_EN
   logic [16:0] drop_sum;

   always_comb begin
      drop_sum = {1'b0, dropped_count};
      for (int i = 0; i < CORES_COUNT; i++)
         drop_sum = drop_sum + 17'(drop[i]);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         dropped_count <= '0;
      else
         dropped_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
   end
`endif

endmodule

// File: tb/tb_fb_write_collector.sv
// Directed bench for fb_write_collector with default parameters (10 lanes, 800x600, 16-bit pixels).
module tb_fb_write_collector;

   logic         clk;
   logic         reset_n;
   logic [159:0] ppu_data;
   logic [319:0] ppu_address;
   logic [9:0]   ppu_valid;
   logic         frame_end;
   logic [31:0]  mem_address;
   logic [15:0]  mem_writedata;
   logic         mem_write;
   logic         mem_waitrequest;
   logic         busy;
   logic         frame_written;
   logic         overflow;
`ifdef FB_WRITE_STATS_EN
   logic [15:0]  dropped_count;
`endif

   int checks;
   int failures;
   int pulses;

   fb_write_collector dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .ppu_data        (ppu_data),
      .ppu_address     (ppu_address),
      .ppu_valid       (ppu_valid),
      .frame_end       (frame_end),
      .mem_address     (mem_address),
      .mem_writedata   (mem_writedata),
      .mem_write       (mem_write),
      .mem_waitrequest (mem_waitrequest),
      .busy            (busy),
      .frame_written   (frame_written),
      .overflow        (overflow)
`ifdef FB_WRITE_STATS_EN
      ,
      .dropped_count   (dropped_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic beat(input int lane, input logic [15:0] d, input logic [31:0] a);
      ppu_valid[lane]            = 1'b1;
      ppu_data[lane*16 +: 16]    = d;
      ppu_address[lane*32 +: 32] = a;
   endtask

   task automatic do_reset();
      ppu_valid       = '0;
      frame_end       = 1'b0;
      mem_waitrequest = 1'b0;
      reset_n         = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      ppu_data    = '0;
      ppu_address = '0;
      do_reset();

      chk("rst_mem_write", 32'(mem_write), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_overflow", 32'(overflow), 0);
      chk("rst_frame_written", 32'(frame_written), 0);
      chk("rst_mem_address", mem_address, 0);

      // single beat, one-cycle latency
      beat(0, 16'hABCD, 5);
      tick();
      ppu_valid = '0;
      chk("t1_write", 32'(mem_write), 1);
      chk("t1_addr", mem_address, 10);
      chk("t1_data", 32'(mem_writedata), 32'hABCD);
      chk("t1_busy", 32'(busy), 1);
      tick();
      chk("t1_write_done", 32'(mem_write), 0);
      chk("t1_busy_done", 32'(busy), 0);

      // round robin 0,3,9 then next round starts after 9
      do_reset();
      beat(0, 16'h1000, 0);
      beat(3, 16'h1003, 3);
      beat(9, 16'h1009, 9);
      tick();
      ppu_valid = '0;
      chk("t2_w0", 32'(mem_write), 1);
      chk("t2_a0", mem_address, 0);
      chk("t2_d0", 32'(mem_writedata), 32'h1000);
      tick();
      chk("t2_w3", 32'(mem_write), 1);
      chk("t2_a3", mem_address, 288006);
      chk("t2_d3", 32'(mem_writedata), 32'h1003);
      tick();
      chk("t2_w9", 32'(mem_write), 1);
      chk("t2_a9", mem_address, 864018);
      chk("t2_d9", 32'(mem_writedata), 32'h1009);
      tick();
      chk("t2_idle", 32'(mem_write), 0);
      beat(9, 16'h2009, 0);
      beat(5, 16'h2005, 0);
      tick();
      ppu_valid = '0;
      chk("t2_r2_first", mem_address, 480000);
      tick();
      chk("t2_r2_second", mem_address, 864000);
      tick();
      chk("t2_r2_idle", 32'(mem_write), 0);

      // lane 2 base address
      beat(2, 16'h0222, 0);
      tick();
      ppu_valid = '0;
      chk("t3_addr", mem_address, 192000);
      chk("t3_data", 32'(mem_writedata), 32'h0222);
      tick();

      // stall with overflow on lane 1
      for (int k = 0; k < 8; k++) begin
         mem_waitrequest = 1'b1;
         if (k < 6) beat(1, 16'(16'h3000 + k), 32'(100 + k));
         tick();
         ppu_valid = '0;
         chk("t4_stall_write", 32'(mem_write), 1);
         chk("t4_stall_addr", mem_address, 96200);
         chk("t4_stall_data", 32'(mem_writedata), 32'h3000);
      end
      chk("t4_busy", 32'(busy), 1);
      chk("t4_overflow", 32'(overflow), 1);
`ifdef FB_WRITE_STATS_EN
      chk("t4_dropped", 32'(dropped_count), 1);
`endif
      mem_waitrequest = 1'b0;
      for (int j = 0; j < 5; j++) begin
         chk("t4_drain_write", 32'(mem_write), 1);
         chk("t4_drain_addr", mem_address, 32'(96200 + 2 * j));
         chk("t4_drain_data", 32'(mem_writedata), 32'(16'h3000 + j));
         tick();
      end
      chk("t4_after_write", 32'(mem_write), 0);
      chk("t4_after_busy", 32'(busy), 0);

      // frame_end with 3 queued beats; rr pointer now at lane 2
      beat(4, 16'h0444, 0);
      beat(6, 16'h0666, 0);
      beat(7, 16'h0777, 0);
      frame_end = 1'b1;
      tick();
      ppu_valid = '0;
      frame_end = 1'b1;
      chk("t5_a4", mem_address, 384000);
      chk("t5_fw_a", 32'(frame_written), 0);
      tick();
      frame_end = 1'b0;
      chk("t5_a6", mem_address, 576000);
      chk("t5_fw_b", 32'(frame_written), 0);
      tick();
      chk("t5_a7", mem_address, 672000);
      chk("t5_w7", 32'(mem_write), 1);
      chk("t5_fw_c", 32'(frame_written), 0);
      tick();
      chk("t5_fw_pulse", 32'(frame_written), 1);
      chk("t5_busy", 32'(busy), 0);
      pulses = 0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (frame_written) pulses++;
      end
      chk("t5_single_pulse", 32'(pulses), 0);
      frame_end = 1'b1;
      tick();
      frame_end = 1'b0;
      chk("t5_idle_fw", 32'(frame_written), 1);
      tick();
      chk("t5_idle_fw_end", 32'(frame_written), 0);

      // async reset mid-stall with queued beats and overflow set
      for (int k = 0; k < 6; k++) begin
         mem_waitrequest = 1'b1;
         beat(8, 16'(16'h0800 + k), 32'(k));
         tick();
         ppu_valid = '0;
      end
      chk("t6_pre_write", 32'(mem_write), 1);
      chk("t6_pre_addr", mem_address, 768000);
      chk("t6_pre_overflow", 32'(overflow), 1);
      reset_n = 1'b0;
      #1;
      chk("t6_rst_write", 32'(mem_write), 0);
      chk("t6_rst_busy", 32'(busy), 0);
      chk("t6_rst_overflow", 32'(overflow), 0);
`ifdef FB_WRITE_STATS_EN
      chk("t6_rst_dropped", 32'(dropped_count), 0);
`endif
      tick();
      reset_n         = 1'b1;
      mem_waitrequest = 1'b0;
      pulses = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (mem_write || busy) pulses++;
      end
      chk("t6_no_write_after", 32'(pulses), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
